// File: rtl/display_scan_ctrl.sv
// Multiplexed display scan controller: walks the enabled digits round-robin,
// each slot a short anode-off guard (BLANK) followed by the on-time (SHOW).
// All outputs come straight from flops.
module display_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic [3:0] digit_en,
    output logic [1:0] digit_sel,
    output logic [3:0] anode_n,
    output logic       frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - BLANK - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      anode_q, anode_d;
    logic            fd_q, fd_d;
    logic [1:0]      adv_idx;

    // First set bit of mask, searching upward from 'from' with wrap 3->0.
    function automatic logic [1:0] first_set(input logic [3:0] mask,
                                             input logic [1:0] from);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = from;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = from + 2'(k);
            if (!found && mask[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign adv_idx = first_set(digit_en, sel_q + 2'd1);

    // Next state, slot counter, digit select and frame pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        sel_d   = sel_q;
        fd_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en && (digit_en != 4'b0000)) begin
                    state_d = S_BLANK;
                    sel_d   = first_set(digit_en, 2'd0);
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (digit_en == 4'b0000) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BLANK;
                        sel_d   = adv_idx;
                        // Wrapping back (or reselecting a lone digit) closes a frame.
                        fd_d    = (adv_idx <= sel_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Disable wins over everything, from any state.
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sel_d   = sel_q;
            fd_d    = 1'b0;
        end
        // Anode drive is decoded from the next state so it lands registered.
        anode_d = (state_d == S_SHOW) ? ~(4'b0001 << sel_d) : 4'b1111;
    end

    // State and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            anode_q <= 4'b1111;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            anode_q <= anode_d;
            fd_q    <= fd_d;
        end
    end

    assign digit_sel  = sel_q;
    assign anode_n    = anode_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a slot-position model.
module tb_display_scan_ctrl;

    localparam int DIV   = 10;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic [3:0] digit_en;
    logic [1:0] digit_sel;
    logic [3:0] anode_n;
    logic       frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: is a scan running, which digit owns the slot, cycles into the slot,
    // and whether this cycle is the frame pulse.
    bit m_active = 1'b0;
    int m_cur    = 0;
    int m_p      = 0;
    bit m_fd     = 1'b0;

    display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .en         (en),
        .digit_en   (digit_en),
        .digit_sel  (digit_sel),
        .anode_n    (anode_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int advance(input logic [3:0] m, input int cur);
        for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
        return cur;
    endfunction

    function automatic int zeros(input logic [3:0] v);
        int z = 0;
        for (int i = 0; i < 4; i++) if (v[i] == 1'b0) z++;
        return z;
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge, then check.
    task automatic tick();
        int nx;
        @(posedge clk);
        if (!en) begin
            m_active = 1'b0;
            m_fd     = 1'b0;
        end else if (!m_active) begin
            m_fd = 1'b0;
            if (digit_en != 4'b0000) begin
                m_active = 1'b1;
                m_cur    = lowest(digit_en);
                m_p      = 0;
            end
        end else if (m_p == DIV - 1) begin
            if (digit_en == 4'b0000) begin
                m_active = 1'b0;
                m_fd     = 1'b0;
            end else begin
                nx    = advance(digit_en, m_cur);
                m_fd  = (nx <= m_cur);
                m_cur = nx;
                m_p   = 0;
            end
        end else begin
            m_p++;
            m_fd = 1'b0;
        end
        #1;
        chk("anode_n", 32'(anode_n),
            (m_active && m_p >= BLANK) ? 32'(~(4'b0001 << m_cur) & 4'hF) : 32'hF);
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        if (m_active) chk("digit_sel", 32'(digit_sel), 32'(m_cur));
        chk("onehot_low", 32'(zeros(anode_n) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Run until the model reaches the given digit and slot position, bounded.
    task automatic run_until(input int cur, input int p);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            if (m_active && m_cur == cur && m_p == p) hit = 1'b1;
        end
        chk("wait_target", 32'(hit), 32'd1);
    endtask

    initial begin
        resetn   = 1'b0;
        en       = 1'b1;
        digit_en = 4'b1111;
        #12;
        chk("rst_anode", 32'(anode_n), 32'hF);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_sel", 32'(digit_sel), 32'd0);
        #5 resetn = 1'b1;

        // All four digits, then sparse and single-digit masks.
        run(90);
        digit_en = 4'b1010;
        run(60);
        digit_en = 4'b0100;
        run(40);

        // Mask shrinks mid-SHOW of digit 1: slot finishes, wraps to digit 0.
        digit_en = 4'b1111;
        run_until(1, 5);
        digit_en = 4'b0001;
        run(25);

        // Scan disable mid-SHOW, then restart.
        digit_en = 4'b0110;
        run_until(2, 6);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(30);

        // Empty mask sampled at SHOW end parks the scan.
        run_until(1, 4);
        digit_en = 4'b0000;
        run(15);
        digit_en = 4'b1001;
        run(25);

        // Randomized segments: masks, enable glitches, mid-slot mask changes.
        for (int s = 0; s < 40; s++) begin
            int len = $urandom_range(3, 45);
            case ($urandom_range(0, 3))
                0: digit_en = 4'($urandom);
                1: digit_en = 4'b0001 << $urandom_range(0, 3);
                2: digit_en = 4'b1111;
                default: digit_en = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            endcase
            en = ($urandom_range(0, 5) != 0);
            run(len);
        end

        // Asynchronous reset mid-SHOW, between clock edges.
        en       = 1'b1;
        digit_en = 4'b1111;
        run_until(2, 5);
        #3 resetn = 1'b0;
        #1;
        chk("async_anode", 32'(anode_n), 32'hF);
        chk("async_sel", 32'(digit_sel), 32'd0);
        chk("async_fd", 32'(frame_done), 32'd0);
        m_active = 1'b0;
        m_fd     = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning total clock cycles per digit slot (blank + show); legal range 4..65535.
REQ-002 The block SHALL have parameter BLANK, default 8, meaning anode-off cycles at the start of each slot; legal range 1..DIV-2.
REQ-003 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port en  input  1  scan enable; 0 forces idle with all anodes off.
REQ-006 The block SHALL have port digit_en  input  4  per-digit enable mask; bit i set means digit i takes part in the scan.
REQ-007 The block SHALL have port digit_sel  output  2  index of the current digit, used to steer the segment-data mux.
REQ-008 The block SHALL have port anode_n  output  4  active-low one-hot anode drive; 4'b1111 means all digits off.
REQ-009 The block SHALL have port frame_done  output  1  single-cycle pulse marking the end of one full scan of the enabled digits.

Function
REQ-010 The block SHALL register all outputs; no combinational path from any input to any output.
REQ-011 The block SHALL implement three states: IDLE, BLANK, SHOW.
REQ-012 The block SHALL keep an internal slot counter wide enough for DIV-1, cleared on every state entry.
REQ-013 In IDLE, the block SHALL hold anode_n=4'b1111 and frame_done=0.
REQ-014 In IDLE with en=1 and digit_en!=0, the block SHALL load digit_sel with the lowest set index of digit_en and enter BLANK on the next edge.
REQ-015 In BLANK, the block SHALL hold anode_n=4'b1111 for exactly BLANK cycles and then enter SHOW.
REQ-016 In SHOW, the block SHALL drive anode_n[digit_sel]=0 with all other bits 1 for exactly DIV-BLANK cycles.
REQ-017 At the end of SHOW, the block SHALL enter BLANK and advance digit_sel to the next set bit of digit_en, searching upward from digit_sel+1 mod 4 (round-robin, 3 wraps to 0).
REQ-018 The block SHALL sample digit_en only at IDLE exit and at SHOW end; mask changes mid-slot SHALL NOT shorten or retarget the current slot.
REQ-019 When the advance in REQ-017 selects an index less than or equal to the current digit_sel, the block SHALL assert frame_done for exactly the first cycle of the following BLANK.
REQ-020 With exactly one digit enabled, the block SHALL reselect that digit on every advance and pulse frame_done once per slot.
REQ-021 If en=0 in any state, the block SHALL enter IDLE on the next edge, with anode_n=4'b1111 from that edge onward.
REQ-022 If digit_en=0 is sampled at SHOW end, the block SHALL enter IDLE instead of BLANK, and frame_done SHALL stay 0.
REQ-023 The block SHALL produce a scan period of exactly N*DIV cycles, where N is the number of enabled digits, under a stable mask and en=1.
REQ-024 The block SHALL never drive more than one anode_n bit low in any cycle.

Reset
REQ-025 While resetn=0, the block SHALL asynchronously force state=IDLE, slot counter=0, digit_sel=2'b00, anode_n=4'b1111, frame_done=0.
REQ-026 After resetn deasserts, the block SHALL leave IDLE no earlier than the first rising clk edge.
REQ-027 Reset asserted mid-SHOW SHALL turn all anodes off immediately, without waiting for a clock edge.

Verification (DIV=10, BLANK=2)
REQ-028 Drive en=1 with digit_en=4'b1111 from reset -> anode_n cycles 1110,1101,1011,0111; each slot is 2 cycles of 1111 then 8 cycles low; frame_done pulses once per 40 cycles, in the cycle after digit 3's SHOW ends.
REQ-029 Drive digit_en=4'b1010 -> digit_sel alternates 1,3; anode_n 1101 then 0111; frame_done pulses every 20 cycles, after digit 3's slot.
REQ-030 Drive digit_en=4'b0100 -> digit_sel stays 2; anode_n alternates 1111 (2 cycles) and 1011 (8 cycles); frame_done pulses every 10 cycles.
REQ-031 Change digit_en from 1111 to 0001 mid-SHOW of digit 1 -> digit 1 completes its 8 show cycles, then digit_sel=0 with frame_done=1 for one cycle; digit 2 is never shown.
REQ-032 Drop en to 0 mid-SHOW -> anode_n=1111 on the next edge and the state is IDLE; on en=1, the scan restarts at the lowest enabled digit with a BLANK phase.
REQ-033 Assert resetn=0 mid-SHOW between clock edges -> anode_n=1111, digit_sel=0 and frame_done=0 immediately; the assertion that no more than one anode_n bit is low holds throughout all scenarios.
